// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, result capture from the ALU/LSB buses,
// in-order retirement and mispredict flush. Optional macro: ROB_BYPASS_EN.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 issueFlag,
  input  logic [1:0]           issueType,
  input  logic [4:0]           issueRd,
  input  logic                 issuePredTaken,
  input  logic [31:0]          issueAltPC,
  output logic [ROB_WIDTH-1:0] issueTag,
  output logic                 full,
  input  logic [ROB_WIDTH-1:0] queryTag1,
  input  logic [ROB_WIDTH-1:0] queryTag2,
  output logic                 queryReady1,
  output logic                 queryReady2,
  output logic [31:0]          queryVal1,
  output logic [31:0]          queryVal2,
  input  logic                 aluFlag,
  input  logic [31:0]          aluVal,
  input  logic [ROB_WIDTH-1:0] aluDest,
  input  logic                 lsbFlag,
  input  logic [31:0]          lsbVal,
  input  logic [ROB_WIDTH-1:0] lsbDest,
  output logic                 commitFlag,
  output logic [4:0]           commitRd,
  output logic [31:0]          commitVal,
  output logic [ROB_WIDTH-1:0] commitTag,
  output logic                 storeCommitFlag,
  output logic                 flushFlag,
  output logic [31:0]          flushPC
);

  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [ROB_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ROB_WIDTH:0]   CNT_ONE = 1;
  localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  rdy;
  logic [1:0]           typ    [ROB_SIZE];
  logic [4:0]           rd     [ROB_SIZE];
  logic                 pred   [ROB_SIZE];
  logic [31:0]          alt_pc [ROB_SIZE];
  logic [31:0]          value  [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count;

  logic                 head_ready;
  logic [31:0]          head_val;
  logic                 do_commit;
  logic                 mispredict;
  logic                 do_issue;
  logic                 alu_wb;
  logic                 lsb_wb;

  logic [ROB_WIDTH-1:0] q_tag [2];
  logic                 q_rdy [2];
  logic [31:0]          q_val [2];

  assign issueTag = tail;
  assign full     = (count == CNT_FULL);

  assign q_tag[0]    = queryTag1;
  assign q_tag[1]    = queryTag2;
  assign queryReady1 = q_rdy[0];
  assign queryReady2 = q_rdy[1];
  assign queryVal1   = q_val[0];
  assign queryVal2   = q_val[1];

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      q_rdy[q] = busy[q_tag[q]] & rdy[q_tag[q]];
      q_val[q] = value[q_tag[q]];
`ifdef ROB_BYPASS_EN
      if (busy[q_tag[q]] && aluFlag && aluDest == q_tag[q]) begin
        q_rdy[q] = 1'b1;
        q_val[q] = aluVal;
      end else if (busy[q_tag[q]] && lsbFlag && lsbDest == q_tag[q]) begin
        q_rdy[q] = 1'b1;
        q_val[q] = lsbVal;
      end
`endif
    end
  end

  always_comb begin
    head_ready = rdy[head];
    head_val   = value[head];
`ifdef ROB_BYPASS_EN
    if (aluFlag && aluDest == head) begin
      head_ready = 1'b1;
      head_val   = aluVal;
    end else if (lsbFlag && lsbDest == head) begin
      head_ready = 1'b1;
      head_val   = lsbVal;
    end
`endif
    do_commit  = busy[head] & head_ready;
    mispredict = do_commit && (typ[head] == T_BRANCH) && (head_val[0] != pred[head]);
    // full is sampled before the edge, so a commit never frees a slot for this cycle's issue
    do_issue   = issueFlag && !full && !mispredict;
    alu_wb     = aluFlag && busy[aluDest];
    lsb_wb     = lsbFlag && busy[lsbDest] && !(aluFlag && aluDest == lsbDest);
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      busy            <= '0;
      rdy             <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      commitFlag      <= 1'b0;
      commitRd        <= '0;
      commitVal       <= '0;
      commitTag       <= '0;
      storeCommitFlag <= 1'b0;
      flushFlag       <= 1'b0;
      flushPC         <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        typ[i]    <= '0;
        rd[i]     <= '0;
        pred[i]   <= 1'b0;
        alt_pc[i] <= '0;
        value[i]  <= '0;
      end
    end else if (readyIn) begin
      commitFlag      <= 1'b0;
      storeCommitFlag <= 1'b0;
      flushFlag       <= 1'b0;
      if (mispredict) begin
        busy      <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        flushFlag <= 1'b1;
        flushPC   <= alt_pc[head];
        commitTag <= head;
      end else begin
        if (alu_wb) begin
          value[aluDest] <= aluVal;
          rdy[aluDest]   <= 1'b1;
        end
        if (lsb_wb) begin
          value[lsbDest] <= lsbVal;
          rdy[lsbDest]   <= 1'b1;
        end
        if (do_issue) begin
          busy[tail]   <= 1'b1;
          rdy[tail]    <= (issueType == T_STORE);
          typ[tail]    <= issueType;
          rd[tail]     <= issueRd;
          pred[tail]   <= issuePredTaken;
          alt_pc[tail] <= issueAltPC;
          tail         <= tail + PTR_ONE;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + PTR_ONE;
          commitTag  <= head;
          if (typ[head] == T_STORE) begin
            storeCommitFlag <= 1'b1;
          end else if (typ[head] != T_BRANCH) begin
            commitFlag <= 1'b1;
            commitRd   <= rd[head];
            commitVal  <= head_val;
          end
        end
        case ({do_issue, do_commit})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
